cache_control: RTL and testbench

Sequencing FSM for the 2-way, 16-set, write-back/write-allocate L1 cache datapath. Sits between the CPU-side request port and physical memory, and drives every load/select strobe of the cache datapath. Services read hits and write hits in one cycle. Services misses by an optional dirty-victim writeback followed by a line fill. Keeps saturating hit, miss and writeback event counters for performance monitoring.

---
 rtl/cache_control_if.sv | 55 +++++
 rtl/cache_control.sv | 129 ++++++++++++
 tb/tb_cache_control.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_control_if.sv
// Request, datapath and memory strobes exchanged with the L1 cache controller.
interface cache_control_if;
  logic        cache_read;
  logic        cache_write;
  logic        cache_resp;
  logic        way1_hit;
  logic        way2_hit;
  logic        read_hit;
  logic        write_hit;
  logic        LRU_out;
  logic        dirty_out;
  logic        R_W;
  logic        load_data_1;
  logic        load_data_2;
  logic        load_dirty_1;
  logic        load_dirty_2;
  logic        dirty_bit;
  logic        load_LRU;
  logic        LRU_in;
  logic        mem_read;
  logic        mem_write;
  logic        mem_resp;
  logic        clear_counters;
  logic [15:0] hit_count;
  logic [15:0] miss_count;
  logic [15:0] wb_count;

  modport master (
    output cache_read, cache_write,
    output way1_hit, way2_hit,
    output read_hit, write_hit,
    output LRU_out, dirty_out,
    output mem_resp, clear_counters,
    input  cache_resp, R_W,
    input  load_data_1, load_data_2,
    input  load_dirty_1, load_dirty_2,
    input  dirty_bit, load_LRU, LRU_in,
    input  mem_read, mem_write,
    input  hit_count, miss_count, wb_count
  );

  modport slave (
    input  cache_read, cache_write,
    input  way1_hit, way2_hit,
    input  read_hit, write_hit,
    input  LRU_out, dirty_out,
    input  mem_resp, clear_counters,
    output cache_resp, R_W,
    output load_data_1, load_data_2,
    output load_dirty_1, load_dirty_2,
    output dirty_bit, load_LRU, LRU_in,
    output mem_read, mem_write,
    output hit_count, miss_count, wb_count
  );
endinterface

// File: rtl/cache_control.sv
// 2-way write-back L1 cache sequencer: one-cycle hits,
// writeback + fill on miss, saturating event counters.
module cache_control (
  input  logic            clk,
  input  logic            reset_n,
  cache_control_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE,
    WRITEBACK,
    ALLOCATE
  } state_e;

  state_e      state_q, state_d;
  logic        miss_pending_q, miss_pending_d;
  logic [15:0] hit_count_q, hit_count_d;
  logic [15:0] miss_count_q, miss_count_d;
  logic [15:0] wb_count_q, wb_count_d;
  logic        hit_inc, miss_inc, wb_inc;
  logic        hit;

  function automatic logic [15:0] bump(
    input logic [15:0] cnt,
    input logic        inc,
    input logic        clr
  );
    logic [15:0] r;
    r = cnt;
    if (clr)
      r = 16'h0000;
    else if (inc && cnt != 16'hFFFF)
      r = cnt + 16'h0001;
    return r;
  endfunction

  always_comb begin
    state_d          = state_q;
    miss_pending_d   = miss_pending_q;
    hit_inc          = 1'b0;
    miss_inc         = 1'b0;
    wb_inc           = 1'b0;
    bus.cache_resp   = 1'b0;
    bus.R_W          = 1'b0;
    bus.load_data_1  = 1'b0;
    bus.load_data_2  = 1'b0;
    bus.load_dirty_1 = 1'b0;
    bus.load_dirty_2 = 1'b0;
    bus.dirty_bit    = 1'b0;
    bus.load_LRU     = 1'b0;
    bus.LRU_in       = 1'b0;
    bus.mem_read     = 1'b0;
    bus.mem_write    = 1'b0;
    // A simultaneous read+write is serviced as a write
    hit = bus.cache_write ? bus.write_hit
                          : (bus.cache_read & bus.read_hit);

    unique case (state_q)
      IDLE: begin
        if (hit) begin
          bus.cache_resp = 1'b1;
          bus.load_LRU   = 1'b1;
          bus.LRU_in     = bus.way1_hit;
          hit_inc        = ~miss_pending_q;
          miss_pending_d = 1'b0;
          if (bus.cache_write) begin
            bus.R_W       = 1'b1;
            bus.dirty_bit = 1'b1;
            if (bus.way1_hit) begin
              bus.load_data_1  = 1'b1;
              bus.load_dirty_1 = 1'b1;
            end else begin
              bus.load_data_2  = 1'b1;
              bus.load_dirty_2 = 1'b1;
            end
          end
        end else if (bus.cache_read | bus.cache_write) begin
          miss_pending_d = 1'b1;
          miss_inc       = 1'b1;
          state_d = bus.dirty_out ? WRITEBACK : ALLOCATE;
        end
      end
      WRITEBACK: begin
        bus.R_W       = 1'b1;
        bus.mem_write = 1'b1;
        if (bus.mem_resp) begin
          wb_inc  = 1'b1;
          state_d = ALLOCATE;
        end
      end
      ALLOCATE: begin
        bus.mem_read = 1'b1;
        if (bus.mem_resp) begin
          bus.load_data_1  = ~bus.LRU_out;
          bus.load_dirty_1 = ~bus.LRU_out;
          bus.load_data_2  = bus.LRU_out;
          bus.load_dirty_2 = bus.LRU_out;
          state_d          = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    hit_count_d  = bump(hit_count_q, hit_inc, bus.clear_counters);
    miss_count_d = bump(miss_count_q, miss_inc, bus.clear_counters);
    wb_count_d   = bump(wb_count_q, wb_inc, bus.clear_counters);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      miss_pending_q <= 1'b0;
      hit_count_q    <= 16'h0000;
      miss_count_q   <= 16'h0000;
      wb_count_q     <= 16'h0000;
    end else begin
      state_q        <= state_d;
      miss_pending_q <= miss_pending_d;
      hit_count_q    <= hit_count_d;
      miss_count_q   <= miss_count_d;
      wb_count_q     <= wb_count_d;
    end
  end

  assign bus.hit_count  = hit_count_q;
  assign bus.miss_count = miss_count_q;
  assign bus.wb_count   = wb_count_q;

endmodule

// File: tb/tb_cache_control.sv
// Randomized transaction-level check of cache_control against
// latency, strobe and counter rules of the cache sequencer.
module tb_cache_control;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  cache_control_if bus ();

  cache_control dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  int errs = 0;
  int checks = 0;

  int m_hit = 0;
  int m_miss = 0;
  int m_wb = 0;
  bit pend = 1'b0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int sat(input int v);
    return (v >= 65535) ? 65535 : v + 1;
  endfunction

  task automatic drive_idle();
    bus.cache_read     = 1'b0;
    bus.cache_write    = 1'b0;
    bus.way1_hit       = 1'b0;
    bus.way2_hit       = 1'b0;
    bus.read_hit       = 1'b0;
    bus.write_hit      = 1'b0;
    bus.mem_resp       = 1'b0;
    bus.clear_counters = 1'b0;
  endtask

  function automatic logic [15:0] all_strobes();
    return {bus.cache_resp, bus.R_W,
            bus.load_data_1, bus.load_data_2,
            bus.load_dirty_1, bus.load_dirty_2,
            bus.dirty_bit, bus.load_LRU, bus.LRU_in,
            bus.mem_read, bus.mem_write, 5'b0};
  endfunction

  task automatic chk_counters(input string tag);
    chk({tag, "_hit"}, 32'(bus.hit_count), 32'(m_hit));
    chk({tag, "_miss"}, 32'(bus.miss_count), 32'(m_miss));
    chk({tag, "_wb"}, 32'(bus.wb_count), 32'(m_wb));
  endtask

  // One CPU request; memory and datapath respond as the bench decides
  task automatic txn(input bit rd, input bit wr, input bit hit,
                     input bit dirty, input bit lru, input bit way,
                     input bit both, input bit drop,
                     input int n, input int m);
    int cyc, resp_at, rd_cyc, wr_cyc, fills, fill_cyc;
    bit filled, done, req_on, bad_mem, bad_rw, eff_way, w1, w2;
    logic [7:0] st, st_exp;
    logic [5:0] fill_st, fill_exp;
    cyc = 0; resp_at = -1; rd_cyc = 0; wr_cyc = 0;
    fills = 0; fill_cyc = -1; filled = hit; done = 1'b0;
    bad_mem = 1'b0; bad_rw = 1'b0;
    st = '0; fill_st = '0;
    eff_way = hit ? (both ? 1'b0 : way) : lru;
    bus.LRU_out = lru;
    bus.dirty_out = dirty;
    while (!done && cyc < 300) begin
      @(negedge clk);
      req_on = !(drop && rd_cyc > 0);
      bus.cache_read = rd && req_on;
      bus.cache_write = wr && req_on;
      w1 = filled && (both || eff_way == 1'b0);
      w2 = filled && (both || eff_way == 1'b1);
      bus.way1_hit = w1;
      bus.way2_hit = w2;
      bus.read_hit = (w1 | w2) && bus.cache_read;
      bus.write_hit = (w1 | w2) && bus.cache_write;
      bus.mem_resp = (bus.mem_read && rd_cyc == n - 1) ||
                     (bus.mem_write && wr_cyc == m - 1);
      #1;
      if (bus.mem_read && bus.mem_write) bad_mem = 1'b1;
      if (bus.mem_read && bus.R_W) bad_rw = 1'b1;
      if (bus.mem_write && !bus.R_W) bad_rw = 1'b1;
      if (bus.mem_read) rd_cyc++;
      if (bus.mem_write) wr_cyc++;
      if ((bus.load_data_1 | bus.load_data_2) && !bus.cache_resp) begin
        fills++;
        fill_cyc = cyc;
        filled = 1'b1;
        fill_st = {bus.load_data_1, bus.load_data_2,
                   bus.load_dirty_1, bus.load_dirty_2,
                   bus.dirty_bit, bus.R_W};
      end
      if (bus.cache_resp && resp_at < 0) begin
        resp_at = cyc;
        st = {bus.R_W, bus.load_data_1, bus.load_data_2,
              bus.load_dirty_1, bus.load_dirty_2,
              bus.dirty_bit, bus.load_LRU, bus.LRU_in};
      end
      cyc++;
      if (!drop && resp_at >= 0) done = 1'b1;
      if (drop && fills > 0 && cyc > fill_cyc + 1) done = 1'b1;
    end
    chk("done", 32'(done), 32'd1);
    chk("mem_excl", 32'(bad_mem), 32'd0);
    chk("rw_mem", 32'(bad_rw), 32'd0);
    chk("rd_cycles", rd_cyc, hit ? 0 : n);
    chk("wr_cycles", wr_cyc, (hit || !dirty) ? 0 : m);
    chk("fills", fills, hit ? 0 : 1);
    if (!hit) begin
      fill_exp = lru ? 6'b010100 : 6'b101000;
      chk("fill_strobes", 32'(fill_st), 32'(fill_exp));
    end
    if (drop) begin
      chk("no_resp", resp_at, -1);
    end else begin
      chk("latency", resp_at + 1,
          hit ? 1 : (n + 2 + (dirty ? m : 0)));
      st_exp = {wr, wr && !eff_way, wr && eff_way,
                wr && !eff_way, wr && eff_way,
                wr, 1'b1, !eff_way};
      chk("resp_strobes", 32'(st), 32'(st_exp));
    end
    if (!hit) begin
      m_miss = sat(m_miss);
      if (dirty) m_wb = sat(m_wb);
      pend = 1'b1;
    end
    if (!drop) begin
      if (hit && !pend) m_hit = sat(m_hit);
      pend = 1'b0;
    end
    @(negedge clk);
    drive_idle();
    #1;
    chk("idle_strobes", 32'(all_strobes()), 32'd0);
    chk_counters("cnt");
  endtask

  initial begin
    int r;
    bit rd, wr, hit, drop;
    drive_idle();
    bus.LRU_out = 1'b0;
    bus.dirty_out = 1'b0;
    bus.cache_read = 1'b1;
    #2;
    chk("reset_strobes", 32'(all_strobes()), 32'd0);
    chk_counters("reset");
    @(negedge clk);
    bus.cache_read = 1'b0;
    reset_n = 1'b1;

    // Clean read miss, then same-line read hit
    txn(1, 0, 0, 0, 0, 0, 0, 0, 3, 1);
    txn(1, 0, 1, 0, 0, 0, 0, 0, 1, 1);
    // Dirty miss into way2
    txn(1, 0, 0, 1, 1, 0, 0, 0, 2, 3);
    // Write hit in way2
    txn(0, 1, 1, 0, 0, 1, 0, 0, 1, 1);
    // Write hitting both ways, read+write together
    txn(1, 1, 1, 0, 1, 1, 1, 0, 1, 1);

    for (int i = 0; i < 150; i++) begin
      r = $urandom_range(0, 9);
      rd = (r < 5) || (r == 9);
      wr = (r >= 5);
      hit = ($urandom_range(0, 9) < 4);
      drop = !hit && ($urandom_range(0, 7) == 0);
      txn(rd, wr, hit, 1'($urandom), 1'($urandom), 1'($urandom),
          hit && ($urandom_range(0, 5) == 0), drop,
          $urandom_range(1, 5), $urandom_range(1, 5));
    end

    // Reset while waiting for a fill
    @(negedge clk);
    bus.LRU_out = 1'b0;
    bus.dirty_out = 1'b0;
    bus.cache_read = 1'b1;
    r = 0;
    while (!bus.mem_read && r < 10) begin
      @(negedge clk);
      #1;
      r++;
    end
    chk("alloc_reached", 32'(bus.mem_read), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("rst_mem_read", 32'(bus.mem_read), 32'd0);
    m_hit = 0; m_miss = 0; m_wb = 0; pend = 1'b0;
    chk_counters("rst");
    bus.cache_read = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    bus.mem_resp = 1'b1;
    #1;
    chk("late_resp", 32'(all_strobes()), 32'd0);
    @(negedge clk);
    bus.mem_resp = 1'b0;

    // Clear wins over a same-cycle hit, then saturate hit_count
    bus.cache_read = 1'b1;
    bus.way1_hit = 1'b1;
    bus.read_hit = 1'b1;
    bus.clear_counters = 1'b1;
    @(negedge clk);
    #1;
    chk("clr_first", 32'(bus.hit_count), 32'd0);
    bus.clear_counters = 1'b0;
    repeat (65535) @(negedge clk);
    #1;
    chk("hit_full", 32'(bus.hit_count), 32'hFFFF);
    @(negedge clk);
    #1;
    chk("hit_sat", 32'(bus.hit_count), 32'hFFFF);
    bus.clear_counters = 1'b1;
    @(negedge clk);
    #1;
    chk("clr_sat", 32'(bus.hit_count), 32'd0);
    drive_idle();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
